// File: rtl/countdown_timer.sv
// countdown_timer: one-second countdown with a built-in rate divider,
// start/pause/clear control, a two-digit seven-segment decode and expiry.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN. When it is defined, the
// timer reloads START_SEC one tick after reaching zero instead of stopping
// in EXPIRED.
module countdown_timer #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned START_SEC = 59,
  parameter int unsigned SEC_W     = 7,
  parameter int unsigned DIV_W     = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [SEC_W-1:0] sec_left,
  output logic [6:0]       hex_tens,
  output logic [6:0]       hex_ones,
  output logic             running,
  output logic             expired,
  output logic             fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EXPIRED
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_INIT   = SEC_W'(START_SEC);
  localparam logic [SEC_W-1:0] SEC_ONE    = SEC_W'(1);
  localparam logic [SEC_W-1:0] SEC_TEN    = SEC_W'(10);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0] sec_q,   sec_d;
  logic             fail_q,  fail_d;

  logic [3:0]       tens_dig, ones_dig;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State, prescaler, seconds and fail registers with async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      sec_q   <= SEC_INIT;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic: clear > start > pause > tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    fail_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      sec_d   = SEC_INIT;
    end else if (start) begin
      state_d = S_RUN;
      presc_d = '0;
      sec_d   = SEC_INIT;
    end else if (state_q == S_RUN && !pause) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (sec_q > SEC_ONE) begin
          sec_d = sec_q - SEC_ONE;
        end else if (sec_q == SEC_ONE) begin
          sec_d  = '0;
          fail_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          state_d = S_RUN;
`else
          state_d = S_EXPIRED;
`endif
        end else begin
          // Zero has been shown for a full tick period: reload and keep going.
          sec_d = SEC_INIT;
        end
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
  end

  // Display digits straight from the registered count.
  always_comb begin
    tens_dig = 4'(sec_q / SEC_TEN);
    ones_dig = 4'(sec_q % SEC_TEN);
  end

  assign sec_left = sec_q;
  assign hex_tens = seg7(tens_dig);
  assign hex_ones = seg7(ones_dig);
  assign running  = (state_q == S_RUN) && !pause;
  assign expired  = (state_q == S_EXPIRED);
  assign fail     = fail_q;

endmodule
